// File: rtl/md_unit_if.sv
// md_unit_if: issue/result bundle between E-stage decode and the MD unit.
// Master drives the op and operands; slave returns Busy and HI/LO.
interface md_unit_if;
    logic        Start;
    logic [3:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Start, Op, A, B,
        input  Busy, HI, LO
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, HI, LO
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with HI/LO and a Busy latency model.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic      Clock,
    input logic      Reset,
    md_unit_if.slave bus
);
    localparam logic [3:0] OP_NONE  = 4'b0000;
    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'b0111;
    localparam logic [3:0] OP_MADDU = 4'b1000;
    localparam logic [3:0] OP_MSUB  = 4'b1001;
    localparam logic [3:0] OP_MSUBU = 4'b1010;
`endif

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [3:0]    op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [31:0]   hi;
    logic [31:0]   lo;

    logic          accept;
    logic          commit;
    logic          is_mul;
    logic          is_div;
    logic          sgn;
    logic          na;
    logic          nb;
    logic [63:0]   prod;
    logic [31:0]   ua;
    logic [31:0]   ub;
    logic [31:0]   uq;
    logic [31:0]   ur;
    logic [31:0]   quo;
    logic [31:0]   rem;
    logic          wr;
    logic [63:0]   res;

    assign accept   = bus.Start && (state == S_IDLE);
    assign bus.Busy = (state == S_BUSY);
    assign bus.HI   = hi;
    assign bus.LO   = lo;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        case (bus.Op)
            OP_MULT, OP_MULTU: is_mul = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU: is_mul = 1'b1;
`endif
            OP_DIV, OP_DIVU:   is_div = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        unique case (state)
            S_IDLE: if (accept && (is_mul || is_div)) state_nx = S_BUSY;
            S_BUSY: if (cnt == '0) begin
                state_nx = S_IDLE;
                commit   = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef MDU_MADD_EN
    assign sgn = (op_q == OP_MULT) || (op_q == OP_DIV) ||
                 (op_q == OP_MADD) || (op_q == OP_MSUB);
`else
    assign sgn = (op_q == OP_MULT) || (op_q == OP_DIV);
`endif

    // Low 64 bits of the extended product are correct for both signednesses.
    assign prod = {{32{sgn & a_q[31]}}, a_q} * {{32{sgn & b_q[31]}}, b_q};

    // Divide on magnitudes so INT_MIN / -1 wraps cleanly instead of trapping.
    assign na  = sgn & a_q[31];
    assign nb  = sgn & b_q[31];
    assign ua  = na ? -a_q : a_q;
    assign ub  = nb ? -b_q : b_q;
    assign uq  = (ub == '0) ? '0 : ua / ub;
    assign ur  = (ub == '0) ? '0 : ua % ub;
    assign quo = (na ^ nb) ? -uq : uq;
    assign rem = na ? -ur : ur;

    always_comb begin
        wr  = 1'b0;
        res = {hi, lo};
        case (op_q)
            OP_MULT, OP_MULTU: begin
                wr  = 1'b1;
                res = prod;
            end
            OP_DIV, OP_DIVU: if (b_q != '0) begin
                wr  = 1'b1;
                res = {rem, quo};
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                wr  = 1'b1;
                res = {hi, lo} + prod;
            end
            OP_MSUB, OP_MSUBU: begin
                wr  = 1'b1;
                res = {hi, lo} - prod;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= OP_NONE;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nx;
            if (accept && (is_mul || is_div)) begin
                cnt  <= is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
                op_q <= bus.Op;
                a_q  <= bus.A;
                b_q  <= bus.B;
            end else if ((state == S_BUSY) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (commit && wr) begin
                hi <= res[63:32];
                lo <= res[31:0];
            end else if (accept && (bus.Op == OP_MTHI)) begin
                hi <= bus.A;
            end else if (accept && (bus.Op == OP_MTLO)) begin
                lo <= bus.A;
            end
        end
    end
endmodule
